// File: rtl/puf_scan_ctrl_pkg.sv
// Shared types and constants for the PUF scan-chain sequencer.
// State encodings are 3-bit binary; TE levels name the chain's two modes.
package puf_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic TE_SHIFT   = 1'b1;
  localparam logic TE_CAPTURE = 1'b0;

endpackage

// File: rtl/puf_scan_ctrl_if.sv
// Host/chain bundle of the PUF scan sequencer.
// slave is the sequencer side; master is the host plus scan chain side.
interface puf_scan_ctrl_if #(
  parameter int N_CHAIN = 5
) ();

  logic               START;
  logic [N_CHAIN-1:0] CHAL;
  logic [N_CHAIN-1:0] MASK_IN;
  logic               SO;
  logic               TE;
  logic               TI;
  logic [N_CHAIN-1:0] MASK;
  logic               BUSY;
  logic               DONE;
  logic [N_CHAIN-1:0] RESP;

  modport master (
    output START, CHAL, MASK_IN, SO,
    input  TE, TI, MASK, BUSY, DONE, RESP
  );

  modport slave (
    input  START, CHAL, MASK_IN, SO,
    output TE, TI, MASK, BUSY, DONE, RESP
  );

endinterface

// File: rtl/puf_step_cnt.sv
// Loadable down-counter timing each sequencer phase.
// zero marks the last cycle of the current phase.
module puf_step_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Reload has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/puf_scan_ctrl.sv
// PUF challenge/response scan sequencer: shift challenge in, capture the core
// response, shift it out and present it in parallel with a DONE pulse.
module puf_scan_ctrl
  import puf_scan_ctrl_pkg::*;
#(
  parameter int N_CHAIN    = 5,
  parameter int CAP_CYCLES = 1,
  parameter int CNT_W      = 3
) (
  input  logic            CP,
  input  logic            RN,
  puf_scan_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0]   LOAD_LAST = CNT_W'(N_CHAIN - 1);
  localparam logic [CNT_W-1:0]   CAP_LAST  = CNT_W'(CAP_CYCLES - 1);
  localparam logic [N_CHAIN-1:0] ALL_ONES  = {N_CHAIN{1'b1}};
  localparam logic [N_CHAIN-1:0] ALL_ZERO  = {N_CHAIN{1'b0}};

  state_e             state_r;
  logic [N_CHAIN-1:0] chal_sh_r;
  logic [N_CHAIN-1:0] mask_lat_r;
  logic [N_CHAIN-2:0] resp_sh_r;
  logic               te_r;
  logic               ti_r;
  logic [N_CHAIN-1:0] mask_r;
  logic               busy_r;
  logic               done_r;
  logic [N_CHAIN-1:0] resp_r;

  logic               cnt_load_s;
  logic [CNT_W-1:0]   cnt_val_s;
  logic               cnt_zero_s;
  logic [N_CHAIN-1:0] resp_full_s;

  // The final scan-out sample goes straight into RESP, so resp_sh_r is N-1 wide.
  assign resp_full_s = {resp_sh_r, bus.SO};

  // Phase counter reload on entry to LOAD, CAPTURE and UNLOAD.
  always_comb begin
    cnt_load_s = 1'b0;
    cnt_val_s  = {CNT_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        cnt_load_s = bus.START;
        cnt_val_s  = LOAD_LAST;
      end
      ST_LOAD: begin
        cnt_load_s = cnt_zero_s;
        cnt_val_s  = CAP_LAST;
      end
      ST_CAPTURE: begin
        cnt_load_s = cnt_zero_s;
        cnt_val_s  = LOAD_LAST;
      end
      default: begin
        cnt_load_s = 1'b0;
        cnt_val_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  puf_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
    .clk      (CP),
    .rst_n    (RN),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  // Sequencer FSM; every output is set for the state being entered.
  always_ff @(posedge CP or negedge RN) begin
    if (!RN) begin
      state_r    <= ST_IDLE;
      chal_sh_r  <= ALL_ZERO;
      mask_lat_r <= ALL_ZERO;
      resp_sh_r  <= {(N_CHAIN-1){1'b0}};
      te_r       <= TE_CAPTURE;
      ti_r       <= 1'b0;
      mask_r     <= ALL_ONES;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      resp_r     <= ALL_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.START) begin
            state_r    <= ST_LOAD;
            ti_r       <= bus.CHAL[N_CHAIN-1];
            chal_sh_r  <= {bus.CHAL[N_CHAIN-2:0], 1'b0};
            mask_lat_r <= bus.MASK_IN;
            te_r       <= TE_SHIFT;
            busy_r     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (cnt_zero_s) begin
            state_r <= ST_CAPTURE;
            te_r    <= TE_CAPTURE;
            ti_r    <= 1'b0;
            mask_r  <= mask_lat_r;
          end else begin
            // MSB first, so cell k ends up holding CHAL[k].
            ti_r      <= chal_sh_r[N_CHAIN-1];
            chal_sh_r <= {chal_sh_r[N_CHAIN-2:0], 1'b0};
          end
        end
        ST_CAPTURE: begin
          if (cnt_zero_s) begin
            state_r <= ST_UNLOAD;
            te_r    <= TE_SHIFT;
            mask_r  <= ALL_ONES;
          end
        end
        ST_UNLOAD: begin
          resp_sh_r <= resp_full_s[N_CHAIN-2:0];
          if (cnt_zero_s) begin
            state_r <= ST_DONE;
            te_r    <= TE_CAPTURE;
            done_r  <= 1'b1;
            resp_r  <= resp_full_s;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          te_r    <= TE_CAPTURE;
          ti_r    <= 1'b0;
          mask_r  <= ALL_ONES;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TE   = te_r;
  assign bus.TI   = ti_r;
  assign bus.MASK = mask_r;
  assign bus.BUSY = busy_r;
  assign bus.DONE = done_r;
  assign bus.RESP = resp_r;

endmodule
